// File: rtl/tm_class_argmax_pkg.sv
// ============================================================================
// Module : tm_class_argmax_pkg
// Brief  : Shared TM constants and the argmax scanner state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tm_class_argmax_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int INT_SIZE    = 32;

   localparam logic [INT_SIZE-1:0] INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/tm_argmax_step.sv
// ============================================================================
// Module : tm_argmax_step
// Brief  : Combinational best/second/best_idx update for one signed sample.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_argmax_step #(
   parameter int INT_SIZE = 32,
   parameter int IDX_W    = 4
) (
   input  logic [INT_SIZE-1:0] sample,
   input  logic [IDX_W-1:0]    idx,
   input  logic [INT_SIZE-1:0] best,
   input  logic [INT_SIZE-1:0] second,
   input  logic [IDX_W-1:0]    best_idx,
   output logic [INT_SIZE-1:0] best_nxt,
   output logic [INT_SIZE-1:0] second_nxt,
   output logic [IDX_W-1:0]    best_idx_nxt
);

   always_comb begin
      best_nxt     = best;
      second_nxt   = second;
      best_idx_nxt = best_idx;
      // Strict compare keeps the earliest index on ties.
      if ($signed(sample) > $signed(best)) begin
         second_nxt   = best;
         best_nxt     = sample;
         best_idx_nxt = idx;
      end else if ($signed(sample) > $signed(second)) begin
         second_nxt = sample;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tm_class_argmax.sv
// ============================================================================
// Module : tm_class_argmax
// Brief  : Snapshots TM class sums on full_done rise, scans for argmax/margin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tm_class_argmax #(
   parameter int NUM_CLASSES = tm_class_argmax_pkg::NUM_CLASSES,
   parameter int INT_SIZE    = tm_class_argmax_pkg::INT_SIZE,
   parameter int IDX_W       = 4,
   parameter int CNT_W       = 16
) (
   input  logic                            clk,
   input  logic                            rst_flag,
   input  logic [NUM_CLASSES*INT_SIZE-1:0] class_sums,
   input  logic                            full_done,
   input  logic                            pred_ready,
   output logic                            pred_valid,
   output logic [IDX_W-1:0]                pred_class,
   output logic [INT_SIZE-1:0]             pred_sum,
   output logic [INT_SIZE:0]               pred_margin,
   output logic                            overrun,
   output logic [CNT_W-1:0]                infer_count
);

   import tm_class_argmax_pkg::*;

   localparam logic [INT_SIZE-1:0] c_INT_MIN  = {1'b1, {(INT_SIZE-1){1'b0}}};
   localparam logic [IDX_W-1:0]    c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_full_done_q;
   logic                  w_edge;
   logic                  w_accept;
   logic [INT_SIZE-1:0]   w_sums [NUM_CLASSES];
   logic [INT_SIZE-1:0]   r_snap [NUM_CLASSES];
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      r_best_idx;
   logic [INT_SIZE-1:0]   r_best;
   logic [INT_SIZE-1:0]   r_second;
   logic [IDX_W-1:0]      w_best_idx_nxt;
   logic [INT_SIZE-1:0]   w_best_nxt;
   logic [INT_SIZE-1:0]   w_second_nxt;
   logic [INT_SIZE:0]     w_margin;

   generate
      for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_unpack
         assign w_sums[k] = class_sums[k*INT_SIZE +: INT_SIZE];
      end
   endgenerate

   assign w_edge   = full_done & ~r_full_done_q;
   assign w_accept = pred_valid & pred_ready;
   // One extra bit so INT_MAX - INT_MIN cannot wrap.
   assign w_margin = {r_best[INT_SIZE-1], r_best} - {r_second[INT_SIZE-1], r_second};

   tm_argmax_step #(
      .INT_SIZE (INT_SIZE),
      .IDX_W    (IDX_W)
   ) u_step (
      .sample       (r_snap[r_idx]),
      .idx          (r_idx),
      .best         (r_best),
      .second       (r_second),
      .best_idx     (r_best_idx),
      .best_nxt     (w_best_nxt),
      .second_nxt   (w_second_nxt),
      .best_idx_nxt (w_best_idx_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst_flag) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_edge) w_state_nxt = SCAN;
         SCAN:    if (r_idx == c_LAST_IDX) w_state_nxt = HOLD;
         HOLD:    if (w_accept) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_flag) begin
         r_full_done_q <= 1'b0;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            r_snap[k] <= '0;
         end
         r_idx       <= '0;
         r_best_idx  <= '0;
         r_best      <= '0;
         r_second    <= '0;
         pred_valid  <= 1'b0;
         pred_class  <= '0;
         pred_sum    <= '0;
         pred_margin <= '0;
         overrun     <= 1'b0;
         infer_count <= '0;
      end else begin
         r_full_done_q <= full_done;
         case (r_state)
            IDLE: begin
               if (w_edge) begin
                  for (int k = 0; k < NUM_CLASSES; k++) begin
                     r_snap[k] <= w_sums[k];
                  end
                  r_idx      <= '0;
                  r_best_idx <= '0;
                  r_best     <= c_INT_MIN;
                  r_second   <= c_INT_MIN;
               end
            end
            SCAN: begin
               if (w_edge) overrun <= 1'b1;
               r_best     <= w_best_nxt;
               r_second   <= w_second_nxt;
               r_best_idx <= w_best_idx_nxt;
               r_idx      <= r_idx + IDX_W'(1);
            end
            HOLD: begin
               // Any edge here is dropped, including one coinciding with accept.
               if (w_edge) overrun <= 1'b1;
               if (!pred_valid) begin
                  pred_valid  <= 1'b1;
                  pred_class  <= r_best_idx;
                  pred_sum    <= r_best;
                  pred_margin <= w_margin;
               end else if (pred_ready) begin
                  pred_valid  <= 1'b0;
                  infer_count <= infer_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tm_class_argmax.sv
// ============================================================================
// Module : tb_tm_class_argmax
// Brief  : Directed and randomized checks of tm_class_argmax against a model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tm_class_argmax;

   localparam int NC = 10;
   localparam int IW = 32;

   logic              clk = 1'b0;
   logic              rst_flag = 1'b1;
   logic [NC*IW-1:0]  class_sums = '0;
   logic              full_done = 1'b0;
   logic              pred_ready = 1'b0;
   logic              pred_valid;
   logic [3:0]        pred_class;
   logic [IW-1:0]     pred_sum;
   logic [IW:0]       pred_margin;
   logic              overrun;
   logic [15:0]       infer_count;

   int                checks = 0;
   int                errors = 0;
   int                exp_cls;
   logic [IW-1:0]     exp_sum;
   logic [IW:0]       exp_margin;
   logic [15:0]       exp_cnt = '0;
   int                arr [NC];

   tm_class_argmax dut (
      .clk         (clk),
      .rst_flag    (rst_flag),
      .class_sums  (class_sums),
      .full_done   (full_done),
      .pred_ready  (pred_ready),
      .pred_valid  (pred_valid),
      .pred_class  (pred_class),
      .pred_sum    (pred_sum),
      .pred_margin (pred_margin),
      .overrun     (overrun),
      .infer_count (infer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NC*IW-1:0] pack(input int a [NC]);
      logic [NC*IW-1:0] v;
      for (int k = 0; k < NC; k++) v[k*IW +: IW] = a[k];
      return v;
   endfunction

   // Winner is the first maximum; runner-up is the max over every other index.
   task automatic model(input logic [NC*IW-1:0] s);
      int     v [NC];
      longint sec;
      for (int k = 0; k < NC; k++) v[k] = s[k*IW +: IW];
      exp_cls = 0;
      for (int k = 1; k < NC; k++) if (v[k] > v[exp_cls]) exp_cls = k;
      sec = (exp_cls == 0) ? longint'(v[1]) : longint'(v[0]);
      for (int k = 0; k < NC; k++) if (k != exp_cls && longint'(v[k]) > sec) sec = v[k];
      exp_sum    = v[exp_cls];
      exp_margin = 33'(longint'(v[exp_cls]) - sec);
   endtask

   task automatic start_infer(input logic [NC*IW-1:0] s);
      @(negedge clk);
      class_sums = s;
      full_done  = 1'b1;
      model(s);
      @(posedge clk);
      #1;
      full_done = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat);
      int cycles = 0;
      while (!pred_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      chk("latency", 64'(cycles), 64'(exp_lat));
   endtask

   task automatic check_result(input string tag);
      chk({tag, "_class"},  64'(pred_class),  64'(exp_cls));
      chk({tag, "_sum"},    64'(pred_sum),    64'(exp_sum));
      chk({tag, "_margin"}, 64'(pred_margin), 64'(exp_margin));
   endtask

   task automatic accept();
      pred_ready = 1'b1;
      @(posedge clk);
      #1;
      pred_ready = 1'b0;
      exp_cnt++;
      chk("valid_drop", 64'(pred_valid), 64'(0));
      chk("infer_count", 64'(infer_count), 64'(exp_cnt));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"},   64'(pred_valid),  64'(0));
      chk({tag, "_class"},   64'(pred_class),  64'(0));
      chk({tag, "_sum"},     64'(pred_sum),    64'(0));
      chk({tag, "_margin"},  64'(pred_margin), 64'(0));
      chk({tag, "_overrun"}, 64'(overrun),     64'(0));
      chk({tag, "_count"},   64'(infer_count), 64'(0));
   endtask

   initial begin
      int seen;
      int dly;
      logic [NC*IW-1:0] v;

      repeat (3) @(posedge clk);
      #1;
      rst_flag = 1'b0;
      check_zero("reset");

      // Tie for best at classes 2 and 4
      arr = '{5, -3, 40, 7, 40, 0, 1, 2, 3, 4};
      start_infer(pack(arr));
      exp_cls = 2; exp_sum = 32'd40; exp_margin = '0;
      wait_valid(11);
      check_result("tie");
      accept();

      arr = '{-10, -20, -30, -40, -50, -60, -70, -80, -90, -100};
      start_infer(pack(arr));
      exp_cls = 0; exp_sum = -32'sd10; exp_margin = 33'd10;
      wait_valid(11);
      check_result("neg");
      accept();

      for (int k = 0; k < NC; k++) v[k*IW +: IW] = 32'h8000_0000;
      v[9*IW +: IW] = 32'h7FFF_FFFF;
      start_infer(v);
      exp_cls = 9; exp_sum = 32'h7FFF_FFFF; exp_margin = 33'h0_FFFF_FFFF;
      wait_valid(11);
      check_result("extreme");
      accept();

      for (int k = 0; k < NC; k++) v[k*IW +: IW] = 32'h8000_0000;
      start_infer(v);
      exp_cls = 0; exp_sum = 32'h8000_0000; exp_margin = '0;
      wait_valid(11);
      check_result("allmin");
      accept();

      // Hold ready low; outputs must not move while inputs churn
      for (int k = 0; k < NC; k++) v[k*IW +: IW] = $urandom;
      start_infer(v);
      wait_valid(11);
      for (int c = 0; c < 20; c++) begin
         class_sums = {10{$urandom}};
         @(posedge clk);
         #1;
         chk("stable_valid", 64'(pred_valid), 64'(1));
         check_result("stable");
      end
      accept();

      // Second edge mid-scan with new sums: dropped, overrun set
      for (int k = 0; k < NC; k++) v[k*IW +: IW] = $urandom;
      start_infer(v);
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      class_sums = {10{$urandom}};
      full_done  = 1'b1;
      @(posedge clk);
      #1;
      full_done = 1'b0;
      wait_valid(7);
      check_result("overrun");
      chk("overrun_set", 64'(overrun), 64'(1));
      accept();
      chk("overrun_sticky", 64'(overrun), 64'(1));

      // Reset in SCAN cycle 5 abandons the result
      for (int k = 0; k < NC; k++) v[k*IW +: IW] = $urandom;
      start_infer(v);
      repeat (4) begin @(posedge clk); #1; end
      rst_flag = 1'b1;
      @(posedge clk);
      #1;
      rst_flag = 1'b0;
      exp_cnt  = '0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         if (pred_valid) seen++;
      end
      chk("no_valid_after_rst", 64'(seen), 64'(0));
      check_zero("midscan_rst");

      for (int k = 0; k < NC; k++) v[k*IW +: IW] = $urandom;
      start_infer(v);
      wait_valid(11);
      check_result("post_rst");
      accept();

      // Randomized runs, some drawn from a tiny range to force ties
      for (int n = 0; n < 25; n++) begin
         for (int k = 0; k < NC; k++) begin
            case (n % 3)
               0:       v[k*IW +: IW] = $urandom;
               1:       v[k*IW +: IW] = 32'($signed($urandom_range(0, 6)) - 3);
               default: v[k*IW +: IW] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF - 32'($urandom_range(0, 2));
            endcase
         end
         start_infer(v);
         wait_valid(11);
         check_result("rand");
         dly = $urandom_range(0, 3);
         repeat (dly) begin @(posedge clk); #1; end
         check_result("rand_hold");
         accept();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
